// File: rtl/rr_queue_scheduler.sv
// ---------------------------------------------------------------------------
// rr_queue_scheduler
//
// Work-conserving round-robin scheduler for four byte queues sharing one
// output channel. Each requester owns a circular queue; every cycle the
// output stage may advance, the next non-empty queue after the last granted
// one is popped into a registered valid/ready output. Empty queues are
// skipped, so they never cost a cycle.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   wen[3:0]  per-queue write enable (bit0=a, bit1=b, bit2=c, bit3=d)
//   a,b,c,d   write data for queues 0..3
//   full[3:0] per-queue full flag, from registered occupancy
//   dout      registered output byte
//   grant     index of the queue that supplied dout
//   valid     dout/grant hold a byte
//   ready     downstream accepts the byte when valid && ready
//   drop_cnt  (only with DROP_CNT_EN) saturating count of dropped writes
//
// Build option: define DROP_CNT_EN to add the drop_cnt output and counter.
// ---------------------------------------------------------------------------
module rr_queue_scheduler #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        wen,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        full,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        grant,
    output logic              valid,
    input  logic              ready
`ifdef DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          last_grant_q, last_grant_d;

    logic [3:0][DATA_W-1:0] wdata;
    logic [3:0][DATA_W-1:0] head_data;
    logic [3:0]             empty;
    logic [3:0]             push;
    logic [3:0]             pop;

    logic                   adv;
    logic                   found;
    logic [1:0]             sel;
    logic [1:0]             scan_idx;

    assign wdata = {d, c, b, a};

    // -----------------------------------------------------------------------
    // Per-queue circular buffers
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_queue
            logic [PTR_W-1:0]  head_q, head_d;
            logic [PTR_W-1:0]  tail_q, tail_d;
            logic [CNT_W-1:0]  count_q, count_d;
            logic [DATA_W-1:0] mem [DEPTH];

            assign empty[gi] = (count_q == '0);
            assign full[gi]  = (count_q == CNT_W'(DEPTH));
            // Full is judged before the edge, so a same-cycle pop does not
            // make room for a write.
            assign push[gi]  = wen[gi] && !full[gi];
            assign head_data[gi] = mem[head_q];

            // Pointers wrap naturally because DEPTH is a power of two.
            always_comb begin
                head_d  = head_q;
                tail_d  = tail_q;
                count_d = count_q;
                if (pop[gi]) begin
                    head_d = head_q + PTR_W'(1);
                end
                if (push[gi]) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                end else begin
                    head_q  <= head_d;
                    tail_q  <= tail_d;
                    count_q <= count_d;
                end
            end

            // Storage is left uninitialised; occupancy alone decides validity.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[tail_q] <= wdata[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin selection: first non-empty queue after last_grant.
    // -----------------------------------------------------------------------
    assign adv = (state_q == IDLE) || ready;

    always_comb begin
        found    = 1'b0;
        sel      = last_grant_q;
        scan_idx = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_grant_q + 2'(k);
            if (!found && !empty[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (adv && found) begin
            pop[sel] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage FSM: IDLE = nothing held, HOLD = byte presented.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (adv) begin
            if (found) begin
                state_d      = HOLD;
                dout_d       = head_data[sel];
                grant_d      = sel;
                last_grant_d = sel;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dout_q       <= '0;
            grant_q      <= '0;
            last_grant_q <= 2'd3;   // queue 0 gets first priority
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign dout  = dout_q;
    assign grant = grant_q;
    assign valid = (state_q == HOLD);

`ifdef DROP_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating count of writes rejected because their queue was full.
    // -----------------------------------------------------------------------
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [2:0] drops;
    logic [8:0] drop_sum;

    always_comb begin
        drops = '0;
        for (int i = 0; i < 4; i++) begin
            drops = drops + 3'(wen[i] && full[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 9'(drops);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
